// File: rtl/fir10_mac_filter.sv
// fir10_mac_filter
// Ten-tap direct-form FIR filter. One signed fix32_28 sample enters a 10-deep
// delay line on each enabled clock. The output is the full-precision sum of
// the ten tap products plus an external offset. That path is combinational
// from the taps and inputs, so the output has zero latency.
//
// Ports
//   clk_0         in   1   system clock, rising edge
//   reset_0       in   1   synchronous active-high, clears the delay line
//   clk_enable_0  in   1   shift enable; when low the taps hold
//   Ai_0          in  32   input sample, signed fix32_28
//   Bi_0..Bi_9    in  32   tap coefficients, signed fix32_28 (Bi_0 = newest)
//   accum_0       in  64   signed fix64_56 offset added to the tap sum
//   mac_out_0     out 64   filter output, signed fix64_56, wraps mod 2^64

// Per-tap signed 32x32 -> 64 multiply. Both operands are sign-extended to
// 64 bits, so the low 64 bits of the product are the exact signed result.
module fir10_tap_mul (
    input  logic [31:0] coef_i,
    input  logic [31:0] samp_i,
    output logic [63:0] prod_o
);
    logic [63:0] coef_ext;
    logic [63:0] samp_ext;

    assign coef_ext = {{32{coef_i[31]}}, coef_i};
    assign samp_ext = {{32{samp_i[31]}}, samp_i};
    assign prod_o   = coef_ext * samp_ext;
endmodule

module fir10_mac_filter (
    input  logic        clk_0,
    input  logic        reset_0,
    input  logic        clk_enable_0,
    input  logic [31:0] Ai_0,
    input  logic [31:0] Bi_0,
    input  logic [31:0] Bi_1,
    input  logic [31:0] Bi_2,
    input  logic [31:0] Bi_3,
    input  logic [31:0] Bi_4,
    input  logic [31:0] Bi_5,
    input  logic [31:0] Bi_6,
    input  logic [31:0] Bi_7,
    input  logic [31:0] Bi_8,
    input  logic [31:0] Bi_9,
    input  logic [63:0] accum_0,
    output logic [63:0] mac_out_0
);
    localparam int NUM_TAPS = 10;

    logic [NUM_TAPS-1:0][31:0] x_q, x_d;   // x_q[0] holds the newest sample
    logic [NUM_TAPS-1:0][31:0] coef;
    logic [NUM_TAPS-1:0][63:0] prod;
    logic [63:0]               sum;

    assign coef = {Bi_9, Bi_8, Bi_7, Bi_6, Bi_5, Bi_4, Bi_3, Bi_2, Bi_1, Bi_0};

    // Delay line next state: shift toward x9 when enabled, otherwise hold.
    always_comb begin
        x_d = x_q;
        if (clk_enable_0) begin
            x_d[0] = Ai_0;
            for (int i = 1; i < NUM_TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
        end
    end

    // Reset takes priority over the enable.
    always_ff @(posedge clk_0) begin
        if (reset_0) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
        fir10_tap_mul u_mul (
            .coef_i (coef[g]),
            .samp_i (x_q[g]),
            .prod_o (prod[g])
        );
    end

    // Unpipelined adder chain. It wraps modulo 2^64 and is not saturated.
    always_comb begin
        sum = accum_0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            sum = sum + prod[i];
        end
    end

    assign mac_out_0 = sum;
endmodule

// File: tb/tb_fir10_mac_filter.sv
module tb_fir10_mac_filter;
    logic        clk_0 = 1'b0;
    logic        reset_0;
    logic        clk_enable_0;
    logic [31:0] Ai_0;
    logic [31:0] b [10];
    logic [63:0] accum_0;
    logic [63:0] mac_out_0;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] nom [10];

    fir10_mac_filter dut (
        .clk_0        (clk_0),
        .reset_0      (reset_0),
        .clk_enable_0 (clk_enable_0),
        .Ai_0         (Ai_0),
        .Bi_0         (b[0]),
        .Bi_1         (b[1]),
        .Bi_2         (b[2]),
        .Bi_3         (b[3]),
        .Bi_4         (b[4]),
        .Bi_5         (b[5]),
        .Bi_6         (b[6]),
        .Bi_7         (b[7]),
        .Bi_8         (b[8]),
        .Bi_9         (b[9]),
        .accum_0      (accum_0),
        .mac_out_0    (mac_out_0)
    );

    always #15 clk_0 = ~clk_0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 ns later, away from the edge.
    task automatic step();
        @(posedge clk_0);
        #1;
    endtask

    task automatic do_reset();
        reset_0 = 1'b1;
        step();
        reset_0 = 1'b0;
    endtask

    initial begin
        nom[0] = 32'h001E4219; nom[1] = 32'h006AAD34; nom[2] = 32'h01536DA6;
        nom[3] = 32'h02997E52; nom[4] = 32'h038A24B7;
        for (int i = 0; i < 5; i++) nom[9-i] = nom[i];
        for (int i = 0; i < 10; i++) b[i] = nom[i];

        reset_0 = 1'b0; clk_enable_0 = 1'b1; Ai_0 = '0; accum_0 = '0;
        #2;

        // Reset then idle
        do_reset();
        chk("reset_zero", mac_out_0, 64'h0);
        step();
        chk("idle_zero", mac_out_0, 64'h0);

        // Positive impulse through all ten taps
        Ai_0 = 32'h10000000;
        step();
        chk("imp_first", mac_out_0, 64'h0001E42190000000);
        Ai_0 = '0;
        for (int j = 1; j < 10; j++) begin
            step();
            if (j == 4) chk("imp_k4", mac_out_0, 64'h0038A24B70000000);
            else        chk($sformatf("imp_k%0d", j), mac_out_0, {4'h0, nom[j], 28'h0});
        end
        step();
        chk("imp_gone", mac_out_0, 64'h0);

        // Step response settles on the DC gain
        Ai_0 = 32'h10000000;
        for (int j = 0; j < 10; j++) step();
        chk("step_10", mac_out_0, 64'h00FFFFFF80000000);
        step();
        chk("step_11", mac_out_0, 64'h00FFFFFF80000000);

        // Negative impulse
        do_reset();
        Ai_0 = 32'hF0000000;
        step();
        chk("neg_first", mac_out_0, 64'hFFFE1BDE70000000);
        Ai_0 = '0;
        for (int j = 1; j < 10; j++) begin
            step();
            chk($sformatf("neg_k%0d", j), mac_out_0, -{4'h0, nom[j], 28'h0});
        end

        // Offset and enable hold
        do_reset();
        accum_0 = 64'd5;
        #1;
        chk("offset_only", mac_out_0, 64'd5);
        Ai_0 = 32'h10000000;
        step();
        chk("offset_imp", mac_out_0, 64'h0001E42190000005);
        Ai_0 = '0;
        clk_enable_0 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("hold_%0d", j), mac_out_0, 64'h0001E42190000005);
        end
        clk_enable_0 = 1'b1;
        step();
        chk("resume_b1", mac_out_0, 64'h0006AAD340000005);
        step();
        chk("resume_b2", mac_out_0, 64'h001536DA60000005);

        // Wrap with maximal operands, then reset mid-stream
        do_reset();
        accum_0 = '0;
        for (int i = 0; i < 10; i++) b[i] = 32'h7FFFFFFF;
        Ai_0 = 32'h7FFFFFFF;
        step();
        chk("wrap_1", mac_out_0, 64'h3FFFFFFF00000001);
        for (int j = 1; j < 10; j++) step();
        chk("wrap_10", mac_out_0, 64'h7FFFFFF60000000A);
        accum_0 = 64'h123;
        reset_0 = 1'b1;
        step();
        chk("reset_mid", mac_out_0, 64'h123);
        reset_0 = 1'b0;
        step();
        chk("after_reset", mac_out_0, 64'h3FFFFFFF00000124);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
